// File: rtl/mem_resp.sv
// Response tracker for MEM-stage data SRAM requests: matches in-order data_ok
// returns to recorded requests, extends load data and retires in order to WB.
module mem_resp #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_fire,
    input  logic        req_is_load,
    input  logic [6:0]  req_load_op,
    input  logic [1:0]  req_addr_lo,
    input  logic [31:0] req_rt_val,
    input  logic [4:0]  req_dest,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    input  logic        flush,
    output logic        req_allow,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_is_load,
    output logic [4:0]  resp_dest,
    output logic [31:0] resp_wdata,
    output logic        busy
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [AW-1:0] r_wr_ptr, r_fill_ptr, r_rd_ptr;
    logic [AW:0]   r_count;

    logic          r_is_load [DEPTH];
    logic [6:0]    r_load_op [DEPTH];
    logic [1:0]    r_addr_lo [DEPTH];
    logic [31:0]   r_rt_val  [DEPTH];
    logic [4:0]    r_dest    [DEPTH];
    logic          r_done    [DEPTH];
    logic          r_cancel  [DEPTH];
    logic [31:0]   r_result  [DEPTH];

    logic          w_full, w_empty, w_alloc, w_fill, w_pop;
    logic          w_head_done, w_head_cancel, w_resp_valid;
    logic [31:0]   w_ext;

    assign w_full  = (r_count == FULL_COUNT);
    assign w_empty = (r_count == '0);
    assign w_alloc = req_fire && !w_full;
    // Uses registered pointers only, so an entry allocated this cycle cannot fill.
    assign w_fill  = data_data_ok &&
                     ((r_fill_ptr != r_wr_ptr) || (w_full && !r_done[r_fill_ptr]));

    assign w_head_done   = r_done[r_rd_ptr];
    assign w_head_cancel = r_cancel[r_rd_ptr];
    assign w_resp_valid  = !w_empty && w_head_done && !w_head_cancel && !flush;
    assign w_pop = (w_resp_valid && resp_ready) || (!w_empty && w_head_done && w_head_cancel);

    // Load data extraction for the entry being filled.
    always_comb begin
        logic [31:0] w_d, w_r, w_sh;
        logic [1:0]  w_a;
        logic [15:0] w_half;
        logic [6:0]  w_op;
        w_d    = data_rdata;
        w_r    = r_rt_val[r_fill_ptr];
        w_a    = r_addr_lo[r_fill_ptr];
        w_op   = r_load_op[r_fill_ptr];
        w_sh   = w_d >> {w_a, 3'b000};
        w_half = w_a[1] ? w_d[31:16] : w_d[15:0];
        w_ext  = 32'h0;
        if (r_is_load[r_fill_ptr]) begin
            if (w_op[0])      w_ext = {{24{w_sh[7]}}, w_sh[7:0]};
            else if (w_op[1]) w_ext = {24'h0, w_sh[7:0]};
            else if (w_op[2]) w_ext = {{16{w_half[15]}}, w_half};
            else if (w_op[3]) w_ext = {16'h0, w_half};
            else if (w_op[4]) w_ext = w_d;
            else if (w_op[5]) begin
                case (w_a)
                    2'd0:    w_ext = {w_d[7:0],  w_r[23:0]};
                    2'd1:    w_ext = {w_d[15:0], w_r[15:0]};
                    2'd2:    w_ext = {w_d[23:0], w_r[7:0]};
                    default: w_ext = w_d;
                endcase
            end else if (w_op[6]) begin
                case (w_a)
                    2'd0:    w_ext = w_d;
                    2'd1:    w_ext = {w_r[31:24], w_d[31:8]};
                    2'd2:    w_ext = {w_r[31:16], w_d[31:16]};
                    default: w_ext = {w_r[31:8],  w_d[31:24]};
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_fill_ptr <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (w_alloc) r_wr_ptr   <= r_wr_ptr + 1'b1;
            if (w_fill)  r_fill_ptr <= r_fill_ptr + 1'b1;
            if (w_pop)   r_rd_ptr   <= r_rd_ptr + 1'b1;
            r_count <= r_count + {{AW{1'b0}}, w_alloc} - {{AW{1'b0}}, w_pop};
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_is_load[gi] <= 1'b0;
                    r_load_op[gi] <= '0;
                    r_addr_lo[gi] <= '0;
                    r_rt_val[gi]  <= '0;
                    r_dest[gi]    <= '0;
                    r_done[gi]    <= 1'b0;
                    r_cancel[gi]  <= 1'b0;
                    r_result[gi]  <= '0;
                end else begin
                    // Marking free slots cancelled is harmless: allocation rewrites cancel.
                    if (flush) r_cancel[gi] <= 1'b1;
                    if (w_pop && r_rd_ptr == AW'(gi)) r_done[gi] <= 1'b0;
                    if (w_alloc && r_wr_ptr == AW'(gi)) begin
                        r_is_load[gi] <= req_is_load;
                        r_load_op[gi] <= req_load_op;
                        r_addr_lo[gi] <= req_addr_lo;
                        r_rt_val[gi]  <= req_rt_val;
                        r_dest[gi]    <= req_dest;
                        r_done[gi]    <= 1'b0;
                        r_cancel[gi]  <= flush;
                    end
                    if (w_fill && r_fill_ptr == AW'(gi)) begin
                        r_result[gi] <= w_ext;
                        r_done[gi]   <= 1'b1;
                    end
                end
            end
        end
    endgenerate

    assign req_allow    = (r_count < FULL_COUNT);
    assign busy         = !w_empty;
    assign resp_valid   = w_resp_valid;
    assign resp_is_load = r_is_load[r_rd_ptr];
    assign resp_dest    = r_dest[r_rd_ptr];
    assign resp_wdata   = r_result[r_rd_ptr];
endmodule

// File: tb/tb_mem_resp.sv
// Directed checks of mem_resp: extension, backpressure, flush, reset.
module tb_mem_resp;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_fire, req_is_load;
    logic [6:0]  req_load_op;
    logic [1:0]  req_addr_lo;
    logic [31:0] req_rt_val;
    logic [4:0]  req_dest;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        flush;
    logic        req_allow, resp_valid, resp_ready, resp_is_load, busy;
    logic [4:0]  resp_dest;
    logic [31:0] resp_wdata;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [6:0] OP_LB = 7'b0000001, OP_LBU = 7'b0000010, OP_LH = 7'b0000100,
                           OP_LHU = 7'b0001000, OP_LW = 7'b0010000, OP_LWL = 7'b0100000,
                           OP_LWR = 7'b1000000;

    mem_resp #(.DEPTH(2)) dut (
        .clk(clk), .reset(reset), .req_fire(req_fire), .req_is_load(req_is_load),
        .req_load_op(req_load_op), .req_addr_lo(req_addr_lo), .req_rt_val(req_rt_val),
        .req_dest(req_dest), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .flush(flush), .req_allow(req_allow), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .resp_is_load(resp_is_load), .resp_dest(resp_dest),
        .resp_wdata(resp_wdata), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end else begin
            $display("ok   %s: %h", tag, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic is_ld, input logic [6:0] op, input logic [1:0] a,
                           input logic [31:0] rt, input logic [4:0] dest);
        req_fire    = 1'b1;
        req_is_load = is_ld;
        req_load_op = op;
        req_addr_lo = a;
        req_rt_val  = rt;
        req_dest    = dest;
    endtask

    // One request, data_ok the next cycle, result checked the cycle after the fill.
    task automatic do_load(input string tag, input logic is_ld, input logic [6:0] op,
                           input logic [1:0] a, input logic [31:0] rt, input logic [4:0] dest,
                           input logic [31:0] rdata, input logic [31:0] exp);
        resp_ready = 1'b1;
        set_req(is_ld, op, a, rt, dest);
        step();
        req_fire = 1'b0;
        data_data_ok = 1'b1;
        data_rdata = rdata;
        check({tag, "_pre_valid"}, {31'b0, resp_valid}, 32'd0);
        step();
        data_data_ok = 1'b0;
        check({tag, "_valid"}, {31'b0, resp_valid}, 32'd1);
        check({tag, "_wdata"}, resp_wdata, exp);
        check({tag, "_dest"}, {27'b0, resp_dest}, {27'b0, dest});
        check({tag, "_is_load"}, {31'b0, resp_is_load}, {31'b0, is_ld});
        step();
        check({tag, "_busy_after"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; req_fire = 0; req_is_load = 0; req_load_op = 0; req_addr_lo = 0;
        req_rt_val = 0; req_dest = 0; data_data_ok = 0; data_rdata = 0; flush = 0;
        resp_ready = 0;
        step(); step();
        check("rst_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_is_load", {31'b0, resp_is_load}, 32'd0);
        check("rst_dest", {27'b0, resp_dest}, 32'd0);
        check("rst_wdata", resp_wdata, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_allow", {31'b0, req_allow}, 32'd1);
        reset = 1'b0;
        step();

        do_load("lb_a3",  1'b1, OP_LB,  2'd3, 32'h0,         5'd5,  32'h80AB_CDEF, 32'hFFFF_FF80);
        do_load("lwl_a1", 1'b1, OP_LWL, 2'd1, 32'h1122_3344, 5'd6,  32'hAABB_CCDD, 32'hCCDD_3344);
        do_load("lwr_a2", 1'b1, OP_LWR, 2'd2, 32'h1122_3344, 5'd7,  32'hAABB_CCDD, 32'h1122_AABB);
        do_load("lhu_a2", 1'b1, OP_LHU, 2'd2, 32'h0,         5'd8,  32'h8001_0000, 32'h0000_8001);
        do_load("lh_a0",  1'b1, OP_LH,  2'd0, 32'h0,         5'd9,  32'h1234_8000, 32'hFFFF_8000);
        do_load("store",  1'b0, OP_LW,  2'd0, 32'hDEAD_BEEF, 5'd0,  32'h5555_5555, 32'h0);

        // Backpressure and full queue
        resp_ready = 1'b0;
        set_req(1'b1, OP_LW, 2'd0, 32'h0, 5'd3);
        step();
        set_req(1'b1, OP_LBU, 2'd1, 32'h0, 5'd4);
        data_data_ok = 1'b1; data_rdata = 32'h1234_5678;
        step();
        req_fire = 1'b0;
        check("bp_allow_full", {31'b0, req_allow}, 32'd0);
        data_data_ok = 1'b1; data_rdata = 32'h0000_AB00;
        check("bp_first_valid", {31'b0, resp_valid}, 32'd1);
        step();
        data_data_ok = 1'b0;
        step();
        check("bp_hold_valid", {31'b0, resp_valid}, 32'd1);
        check("bp_hold_wdata", resp_wdata, 32'h1234_5678);
        check("bp_hold_dest", {27'b0, resp_dest}, 32'd3);
        resp_ready = 1'b1;
        step();
        check("bp_second_valid", {31'b0, resp_valid}, 32'd1);
        check("bp_second_wdata", resp_wdata, 32'h0000_00AB);
        check("bp_second_dest", {27'b0, resp_dest}, 32'd4);
        check("bp_allow_back", {31'b0, req_allow}, 32'd1);
        step();
        check("bp_empty", {31'b0, busy}, 32'd0);

        // Flush with an outstanding load
        set_req(1'b1, OP_LW, 2'd0, 32'h0, 5'd12);
        step();
        req_fire = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        check("fl_wait1_valid", {31'b0, resp_valid}, 32'd0);
        step();
        check("fl_wait2_valid", {31'b0, resp_valid}, 32'd0);
        data_data_ok = 1'b1; data_rdata = 32'hCAFE_F00D;
        step();
        data_data_ok = 1'b0;
        check("fl_after_fill_valid", {31'b0, resp_valid}, 32'd0);
        check("fl_after_fill_busy", {31'b0, busy}, 32'd1);
        step();
        check("fl_drained_busy", {31'b0, busy}, 32'd0);
        check("fl_drained_valid", {31'b0, resp_valid}, 32'd0);
        do_load("fl_next", 1'b1, OP_LW, 2'd0, 32'h0, 5'd13, 32'h0BAD_F00D, 32'h0BAD_F00D);

        // Flush coinciding with an allocation and a fill
        set_req(1'b1, OP_LW, 2'd0, 32'h0, 5'd14);
        step();
        set_req(1'b1, OP_LW, 2'd0, 32'h0, 5'd15);
        data_data_ok = 1'b1; data_rdata = 32'h1111_1111; flush = 1'b1;
        check("sim_flush_valid", {31'b0, resp_valid}, 32'd0);
        step();
        req_fire = 1'b0; flush = 1'b0; data_rdata = 32'h2222_2222;
        check("sim_cnt2_allow", {31'b0, req_allow}, 32'd0);
        check("sim_a_valid", {31'b0, resp_valid}, 32'd0);
        step();
        data_data_ok = 1'b0;
        check("sim_b_valid", {31'b0, resp_valid}, 32'd0);
        check("sim_b_busy", {31'b0, busy}, 32'd1);
        step();
        check("sim_drained_busy", {31'b0, busy}, 32'd0);
        check("sim_drained_allow", {31'b0, req_allow}, 32'd1);

        // Asynchronous reset with two entries pending
        resp_ready = 1'b0;
        set_req(1'b1, OP_LW, 2'd0, 32'h0, 5'd10);
        step();
        set_req(1'b1, OP_LW, 2'd0, 32'h0, 5'd11);
        data_data_ok = 1'b1; data_rdata = 32'h3333_3333;
        step();
        req_fire = 1'b0; data_data_ok = 1'b0;
        check("mr_pre_dest", {27'b0, resp_dest}, 32'd10);
        check("mr_pre_allow", {31'b0, req_allow}, 32'd0);
        #2 reset = 1'b1;
        #1;
        check("mr_valid", {31'b0, resp_valid}, 32'd0);
        check("mr_busy", {31'b0, busy}, 32'd0);
        check("mr_allow", {31'b0, req_allow}, 32'd1);
        check("mr_dest", {27'b0, resp_dest}, 32'd0);
        check("mr_wdata", resp_wdata, 32'd0);
        step();
        reset = 1'b0;
        data_data_ok = 1'b1; data_rdata = 32'h4444_4444;
        step();
        data_data_ok = 1'b0;
        check("mr_stray_busy", {31'b0, busy}, 32'd0);
        check("mr_stray_valid", {31'b0, resp_valid}, 32'd0);
        do_load("mr_next", 1'b1, OP_LB, 2'd1, 32'h0, 5'd17, 32'h0000_7F00, 32'h0000_007F);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
